// File: rtl/wb_mux_timeout.sv
`default_nettype none
// ============================================================================
// Module      : wb_mux_timeout
// Description : Single-master Wishbone B4 demultiplexer with mask/match decode,
//               no-match error, per-access watchdog and burst hold-over.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_mux_timeout #(
  parameter int                       NUM_SLAVES = 4,
  parameter int                       AW         = 32,
  parameter int                       DW         = 32,
  parameter logic [NUM_SLAVES*AW-1:0] MATCH_ADDR = {32'hB300_0000, 32'hB200_0000,
                                                    32'hB100_0000, 32'hB000_0000},
  parameter logic [NUM_SLAVES*AW-1:0] MATCH_MASK = {32'hFFFF_0000, 32'hFFFF_0000,
                                                    32'hFF00_0000, 32'hFF00_0000},
  parameter int                       TIMEOUT    = 255
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic [AW-1:0]              wbm_adr_i,
  input  logic [DW-1:0]              wbm_dat_i,
  input  logic [DW/8-1:0]            wbm_sel_i,
  input  logic                       wbm_we_i,
  input  logic                       wbm_cyc_i,
  input  logic                       wbm_stb_i,
  input  logic [2:0]                 wbm_cti_i,
  input  logic [1:0]                 wbm_bte_i,
  output logic [DW-1:0]              wbm_dat_o,
  output logic                       wbm_ack_o,
  output logic                       wbm_err_o,
  output logic                       wbm_rty_o,
  output logic [NUM_SLAVES*AW-1:0]   wbs_adr_o,
  output logic [NUM_SLAVES*DW-1:0]   wbs_dat_o,
  output logic [NUM_SLAVES*DW/8-1:0] wbs_sel_o,
  output logic [NUM_SLAVES-1:0]      wbs_we_o,
  output logic [NUM_SLAVES*3-1:0]    wbs_cti_o,
  output logic [NUM_SLAVES*2-1:0]    wbs_bte_o,
  output logic [NUM_SLAVES-1:0]      wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]      wbs_stb_o,
  input  logic [NUM_SLAVES*DW-1:0]   wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]      wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]      wbs_err_i,
  input  logic [NUM_SLAVES-1:0]      wbs_rty_i,
  output logic                       err_pulse_o,
  output logic [AW-1:0]              err_addr_o,
  output logic [1:0]                 err_cause_o
);

  localparam int C_CW_RAW = $clog2(TIMEOUT + 1);
  localparam int C_CW     = (C_CW_RAW < 8) ? 8 : ((C_CW_RAW > 16) ? 16 : C_CW_RAW);
  localparam bit C_WD_EN  = (TIMEOUT > 0);
  localparam logic [C_CW-1:0] C_LIMIT = C_WD_EN ? C_CW'(TIMEOUT - 1) : '0;

  localparam logic [1:0] C_CAUSE_NOMATCH = 2'b01;
  localparam logic [1:0] C_CAUSE_TIMEOUT = 2'b10;
  localparam logic [2:0] C_CTI_INCR      = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t                r_state;
  logic [NUM_SLAVES-1:0] r_sel;
  logic [C_CW-1:0]       r_cnt;
  logic [AW-1:0]         r_err_addr;
  logic [1:0]            r_err_cause;

  logic [NUM_SLAVES-1:0] w_dec;
  logic                  w_hit;
  logic [DW-1:0]         w_s_dat;
  logic                  w_s_ack;
  logic                  w_s_err;
  logic                  w_s_rty;
  logic                  w_active;
  logic                  w_fwd_ack;
  logic                  w_fwd_err;
  logic                  w_fwd_rty;

  // Scan from the top down so the lowest matching index is the last written.
  always_comb begin
    w_dec = '0;
    w_hit = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((wbm_adr_i & MATCH_MASK[i*AW +: AW]) == MATCH_ADDR[i*AW +: AW]) begin
        w_dec    = '0;
        w_dec[i] = 1'b1;
        w_hit    = 1'b1;
      end
    end
  end

  always_comb begin
    w_s_dat = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_s_dat = w_s_dat | ({DW{r_sel[i]}} & wbs_dat_i[i*DW +: DW]);
    end
  end

  assign w_s_ack   = |(wbs_ack_i & r_sel);
  assign w_s_err   = |(wbs_err_i & r_sel);
  assign w_s_rty   = |(wbs_rty_i & r_sel);
  assign w_active  = (r_state == S_BUSY) && wbm_cyc_i;

  // Exactly one response reaches the master: err, then ack, then rty.
  assign w_fwd_err = w_active & w_s_err;
  assign w_fwd_ack = w_active & w_s_ack & ~w_s_err;
  assign w_fwd_rty = w_active & w_s_rty & ~w_s_err & ~w_s_ack;

  assign wbm_ack_o   = w_fwd_ack;
  assign wbm_rty_o   = w_fwd_rty;
  assign wbm_err_o   = w_fwd_err | (r_state == S_ERR);
  assign wbm_dat_o   = (r_state == S_BUSY) ? w_s_dat : '0;
  assign err_pulse_o = (r_state == S_ERR);
  assign err_addr_o  = r_err_addr;
  assign err_cause_o = r_err_cause;

  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
      assign wbs_adr_o[gi*AW +: AW]       = wbm_adr_i;
      assign wbs_dat_o[gi*DW +: DW]       = wbm_dat_i;
      assign wbs_sel_o[gi*DW/8 +: DW/8]   = wbm_sel_i;
      assign wbs_we_o[gi]                 = wbm_we_i;
      assign wbs_cti_o[gi*3 +: 3]         = wbm_cti_i;
      assign wbs_bte_o[gi*2 +: 2]         = wbm_bte_i;
      assign wbs_cyc_o[gi] = (r_state == S_BUSY) & r_sel[gi] & wbm_cyc_i;
      assign wbs_stb_o[gi] = (r_state == S_BUSY) & r_sel[gi] & wbm_stb_i;
    end
  endgenerate

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= S_IDLE;
      r_sel       <= '0;
      r_cnt       <= '0;
      r_err_addr  <= '0;
      r_err_cause <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (wbm_cyc_i && wbm_stb_i) begin
            if (w_hit) begin
              r_sel   <= w_dec;
              r_state <= S_BUSY;
            end else begin
              r_err_addr  <= wbm_adr_i;
              r_err_cause <= C_CAUSE_NOMATCH;
              r_state     <= S_ERR;
            end
          end
        end
        S_BUSY: begin
          if (!wbm_cyc_i) begin
            r_sel   <= '0;
            r_state <= S_IDLE;
          end else if (w_s_ack || w_s_err || w_s_rty) begin
            // An acked incrementing beat keeps the slave selected for the next beat.
            if (w_fwd_ack && (wbm_cti_i == C_CTI_INCR)) begin
              r_cnt <= '0;
            end else begin
              r_sel   <= '0;
              r_state <= S_IDLE;
            end
          end else if (C_WD_EN && (r_cnt == C_LIMIT)) begin
            r_sel       <= '0;
            r_err_addr  <= wbm_adr_i;
            r_err_cause <= C_CAUSE_TIMEOUT;
            r_state     <= S_ERR;
          end else begin
            r_cnt <= r_cnt + C_CW'(1);
          end
        end
        S_ERR: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_sel   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_mux_timeout.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_mux_timeout
// Description : Directed self-checking bench for wb_mux_timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_mux_timeout;
  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i;
  logic [AW-1:0]     wbm_adr_i;
  logic [DW-1:0]     wbm_dat_i;
  logic [DW/8-1:0]   wbm_sel_i;
  logic              wbm_we_i, wbm_cyc_i, wbm_stb_i;
  logic [2:0]        wbm_cti_i;
  logic [1:0]        wbm_bte_i;
  logic [DW-1:0]     wbm_dat_o;
  logic              wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [NS*AW-1:0]  wbs_adr_o;
  logic [NS*DW-1:0]  wbs_dat_o;
  logic [NS*DW/8-1:0] wbs_sel_o;
  logic [NS-1:0]     wbs_we_o;
  logic [NS*3-1:0]   wbs_cti_o;
  logic [NS*2-1:0]   wbs_bte_o;
  logic [NS-1:0]     wbs_cyc_o, wbs_stb_o;
  logic [NS*DW-1:0]  wbs_dat_i;
  logic [NS-1:0]     wbs_ack_i, wbs_err_i, wbs_rty_i;
  logic              err_pulse_o;
  logic [AW-1:0]     err_addr_o;
  logic [1:0]        err_cause_o;

  int total = 0;
  int bad   = 0;
  int held;

  wb_mux_timeout dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
    .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
    .err_pulse_o(err_pulse_o), .err_addr_o(err_addr_o), .err_cause_o(err_cause_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic nxt();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] adr, input logic we, input logic [2:0] cti);
    wbm_adr_i = adr;
    wbm_we_i  = we;
    wbm_cti_i = cti;
    wbm_cyc_i = 1'b1;
    wbm_stb_i = 1'b1;
  endtask

  task automatic release_bus();
    wbm_cyc_i = 1'b0;
    wbm_stb_i = 1'b0;
    wbm_cti_i = 3'b000;
    wbs_ack_i = '0;
    wbs_err_i = '0;
    wbs_rty_i = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    wb_rst_i  = 1'b1;
    wbm_adr_i = '0;
    wbm_dat_i = 32'hDEAD_BEEF;
    wbm_sel_i = 4'hF;
    wbm_we_i  = 1'b0;
    wbm_bte_i = 2'b00;
    wbs_dat_i = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    release_bus();
    nxt();
    nxt();
    #1;
    chk("rst_cyc", wbs_cyc_o, 0);
    chk("rst_resp", {wbm_ack_o, wbm_err_o, wbm_rty_o, err_pulse_o}, 0);
    chk("rst_dat", wbm_dat_o, 0);
    chk("rst_err_addr", err_addr_o, 0);
    chk("rst_cause", err_cause_o, 0);
    wb_rst_i = 1'b0;

    // Single write to slave 2
    nxt();
    start(32'hB200_0010, 1'b1, 3'b000);
    #1;
    chk("wr_decode_nostb", wbs_stb_o, 0);
    nxt();
    wbs_ack_i = 4'b0100;
    #1;
    chk("wr_cyc", wbs_cyc_o, 4'b0100);
    chk("wr_stb", wbs_stb_o, 4'b0100);
    chk("wr_ack", wbm_ack_o, 1);
    chk("wr_bcast_adr", wbs_adr_o[2*AW +: AW], 32'hB200_0010);
    chk("wr_bcast_dat", wbs_dat_o[0 +: DW], 32'hDEAD_BEEF);
    release_bus();
    nxt();
    #1;
    chk("wr_idle_stb", wbs_stb_o, 0);
    chk("wr_idle_ack", wbm_ack_o, 0);

    // No-match read
    start(32'hC000_0000, 1'b0, 3'b000);
    nxt();
    #1;
    chk("nm_stb", wbs_stb_o, 0);
    chk("nm_err", wbm_err_o, 1);
    chk("nm_pulse", err_pulse_o, 1);
    chk("nm_addr", err_addr_o, 32'hC000_0000);
    chk("nm_cause", err_cause_o, 2'b01);
    release_bus();
    nxt();
    #1;
    chk("nm_err_once", wbm_err_o, 0);
    chk("nm_pulse_once", err_pulse_o, 0);

    // Watchdog expiry on slave 1
    start(32'hB100_0040, 1'b0, 3'b000);
    nxt();
    #1;
    held = 0;
    while (wbs_stb_o[1] && held < 300) begin
      held++;
      nxt();
      #1;
    end
    chk("to_held_cycles", held, 255);
    chk("to_stb_dropped", wbs_stb_o, 0);
    chk("to_err", wbm_err_o, 1);
    chk("to_pulse", err_pulse_o, 1);
    chk("to_cause", err_cause_o, 2'b10);
    chk("to_addr", err_addr_o, 32'hB100_0040);
    release_bus();
    nxt();
    #1;
    chk("to_err_once", wbm_err_o, 0);

    // Ack lands in the expiry cycle: response wins
    start(32'hB100_0080, 1'b0, 3'b000);
    nxt();
    for (int k = 1; k < 255; k++) nxt();
    wbs_ack_i = 4'b0010;
    #1;
    chk("late_stb", wbs_stb_o, 4'b0010);
    chk("late_ack", wbm_ack_o, 1);
    chk("late_noerr", wbm_err_o, 0);
    chk("late_dat", wbm_dat_o, 32'h1111_1111);
    release_bus();
    nxt();
    #1;
    chk("late_after_err", {wbm_err_o, err_pulse_o}, 0);
    chk("late_addr_kept", err_addr_o, 32'hB100_0040);

    // 4-beat incrementing burst to slave 0
    start(32'hB000_0000, 1'b0, 3'b010);
    nxt();
    wbs_ack_i = 4'b0001;
    for (int b = 0; b < 4; b++) begin
      wbm_adr_i = 32'hB000_0000 + 32'(4 * b);
      wbm_cti_i = (b == 3) ? 3'b111 : 3'b010;
      #1;
      chk("burst_stb", wbs_stb_o, 4'b0001);
      chk("burst_ack", wbm_ack_o, 1);
      if (b == 3) release_bus();
      nxt();
    end
    #1;
    chk("burst_end_stb", wbs_stb_o, 0);
    chk("burst_end_ack", wbm_ack_o, 0);

    // Master abandons a slave 3 access after 3 BUSY cycles
    start(32'hB300_0004, 1'b1, 3'b000);
    nxt();
    #1;
    chk("drop_cyc_busy", wbs_cyc_o, 4'b1000);
    nxt();
    nxt();
    wbm_cyc_i = 1'b0;
    wbm_stb_i = 1'b0;
    #1;
    chk("drop_cyc_same", wbs_cyc_o, 0);
    chk("drop_noresp", {wbm_ack_o, wbm_err_o, wbm_rty_o}, 0);
    nxt();
    #1;
    chk("drop_noerr_next", {wbm_err_o, err_pulse_o}, 0);
    start(32'hB200_0020, 1'b0, 3'b000);
    nxt();
    wbs_ack_i = 4'b0100;
    #1;
    chk("after_drop_stb", wbs_stb_o, 4'b0100);
    chk("after_drop_ack", wbm_ack_o, 1);
    chk("after_drop_dat", wbm_dat_o, 32'h2222_2222);
    release_bus();
    nxt();

    // Slave err and ack together: err wins
    start(32'hB300_0000, 1'b0, 3'b000);
    nxt();
    wbs_ack_i = 4'b1000;
    wbs_err_i = 4'b1000;
    #1;
    chk("prio_resp", {wbm_ack_o, wbm_err_o, wbm_rty_o}, 3'b010);
    chk("prio_nopulse", err_pulse_o, 0);
    release_bus();
    nxt();

    // Reset mid-BUSY
    start(32'hB000_0100, 1'b0, 3'b000);
    nxt();
    #1;
    chk("rst_mid_busy", wbs_stb_o, 4'b0001);
    wb_rst_i = 1'b1;
    nxt();
    wb_rst_i = 1'b0;
    #1;
    chk("rst_mid_stb", wbs_stb_o, 0);
    chk("rst_mid_resp", {wbm_ack_o, wbm_err_o, wbm_rty_o, err_pulse_o}, 0);
    chk("rst_mid_cause", err_cause_o, 2'b00);
    release_bus();
    nxt();
    start(32'hB100_0000, 1'b1, 3'b000);
    nxt();
    wbs_ack_i = 4'b0010;
    #1;
    chk("post_rst_stb", wbs_stb_o, 4'b0010);
    chk("post_rst_ack", wbm_ack_o, 1);
    release_bus();
    nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
